if_fetch_queue: RTL and testbench

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/if_fetch_queue_pkg.sv | 23 ++
 rtl/if_fetch_queue_sync_fifo.sv | 59 +++++
 rtl/if_fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_if_fetch_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared front-end types: buffer entry, in-flight tag and the default boot PC.
package if_fetch_queue_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h1c000000;

  // One decoded-side slot: fetched word, its PC, and an address-error flag.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adef;
  } ibuf_entry_t;

  // Travels alongside each accepted SRAM request until its data returns.
  typedef struct packed {
    logic [31:0] pc;
    logic        adef;
  } fetch_tag_t;

  function automatic logic pc_misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_fetch_queue_sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear. Clear drops all
// contents; a push in the same cycle lands as the only entry.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr, wr_sel;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths also work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && (clr || !full || do_pop);
  assign wr_sel  = clr ? '0 : wr_ptr;
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_sel] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= do_push ? bump(AW'(0)) : '0;
      count  <= do_push ? CW'(1) : '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch front end: issues pipelined SRAM fetches, tags them in
// flight, buffers returned words for ID, and handles branch/flush redirects
// by discarding stale returns. Misaligned targets produce one adef entry.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          MAX_OUTST  = 2,
  parameter int          IBUF_DEPTH = 4,
  parameter logic [31:0] RESET_PC   = CPU_RESET_PC
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        id_allowin,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_inst,
  output logic [31:0] if_to_id_pc,
  output logic        if_to_id_adef
);

  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int TW = $clog2(MAX_OUTST) + 1;
  localparam int CW = $clog2(IBUF_DEPTH) + 1;

  logic          run, adef_halt;
  logic [31:0]   fetch_pc, pflush_pc, pbr_pc, addr_sel;
  logic          pflush_vld, pbr_vld;
  logic [OW-1:0] discard;
  logic          br_eff, redirect, misal, hold, issue, adef_push, live_ret;
  int            outst;

  logic [TW-1:0] tag_cnt;
  logic          tag_empty, tag_full;
  fetch_tag_t    tag_in, tag_head;

  logic [CW-1:0] ibuf_cnt;
  logic          ibuf_empty, ibuf_full, ibuf_push;
  ibuf_entry_t   ib_in, ib_head;

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'h2;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_wdata = 32'h0;

  // A branch seen while a flush is still waiting belongs to the killed path.
  assign br_eff   = br_taken && !pflush_vld;
  assign redirect = flush || br_eff;

  // Live tags plus stale returns still owed = everything the SRAM holds.
  assign outst = int'(tag_cnt) + int'(discard);

  // Fetch address: the freshest redirect wins over older state.
  always_comb begin
    addr_sel = fetch_pc;
    if (flush)           addr_sel = flush_target;
    else if (pflush_vld) addr_sel = pflush_pc;
    else if (br_taken)   addr_sel = br_target;
    else if (pbr_vld)    addr_sel = pbr_pc;
  end

  assign misal = pc_misaligned(addr_sel);
  assign hold  = !run || br_stall || tag_full || ibuf_full ||
                 (outst >= MAX_OUTST) ||
                 ((outst + int'(ibuf_cnt)) >= IBUF_DEPTH) ||
                 (discard != '0) || (adef_halt && !redirect);

  assign inst_sram_req  = !hold && !misal;
  assign inst_sram_addr = addr_sel;
  assign issue          = inst_sram_req && inst_sram_addr_ok;
  // The error entry waits until the pipe is drained so it stays in order.
  assign adef_push      = !hold && misal && (outst == 0) && !redirect;
  assign live_ret       = inst_sram_data_ok && (discard == '0) && !tag_empty;

  assign tag_in = '{pc: addr_sel, adef: 1'b0};

  // Buffer entry: returned word, or a zero word flagged as address error.
  always_comb begin
    ib_in = '{inst: inst_sram_rdata, pc: tag_head.pc, adef: tag_head.adef};
    if (adef_push) ib_in = '{inst: 32'h0, pc: addr_sel, adef: 1'b1};
  end

  assign ibuf_push = !redirect && (live_ret || adef_push);

  sync_fifo #(.WIDTH($bits(fetch_tag_t)), .DEPTH(MAX_OUTST)) u_tag_fifo (
    .clk    (clk),
    .resetn (resetn),
    .clr    (redirect),
    .push   (issue),
    .din    (tag_in),
    .pop    (live_ret),
    .dout   (tag_head),
    .empty  (tag_empty),
    .full   (tag_full),
    .count  (tag_cnt)
  );

  sync_fifo #(.WIDTH($bits(ibuf_entry_t)), .DEPTH(IBUF_DEPTH)) u_ibuf (
    .clk    (clk),
    .resetn (resetn),
    .clr    (redirect),
    .push   (ibuf_push),
    .din    (ib_in),
    .pop    (if_to_id_valid && id_allowin),
    .dout   (ib_head),
    .empty  (ibuf_empty),
    .full   (ibuf_full),
    .count  (ibuf_cnt)
  );

  assign if_to_id_valid = !ibuf_empty;
  assign if_to_id_inst  = ib_head.inst;
  assign if_to_id_pc    = ib_head.pc;
  assign if_to_id_adef  = ib_head.adef;

  // Fetch PC, pending redirects, stale-return count and adef halt.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run        <= 1'b0;
      fetch_pc   <= RESET_PC;
      pflush_vld <= 1'b0;
      pflush_pc  <= '0;
      pbr_vld    <= 1'b0;
      pbr_pc     <= '0;
      discard    <= '0;
      adef_halt  <= 1'b0;
    end else begin
      run <= 1'b1;
      if (issue) fetch_pc <= addr_sel + 32'd4;

      if (issue || adef_push) begin
        pflush_vld <= 1'b0;
        pbr_vld    <= 1'b0;
      end else if (flush) begin
        pflush_vld <= 1'b1;
        pflush_pc  <= flush_target;
        pbr_vld    <= 1'b0;
      end else if (br_eff) begin
        pbr_vld <= 1'b1;
        pbr_pc  <= br_target;
      end

      if (redirect)
        discard <= OW'(outst - int'(inst_sram_data_ok));
      else if (inst_sram_data_ok && discard != '0)
        discard <= discard - OW'(1);

      if (redirect)       adef_halt <= 1'b0;
      else if (adef_push) adef_halt <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: SRAM model with random accept/latency, ID side
// with random backpressure, and an architectural next-PC reference.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam int          MAXO = 2;
  localparam logic [31:0] RPC  = 32'h1c000000;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        inst_sram_req, inst_sram_wr;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok = 1'b0, inst_sram_data_ok = 1'b0;
  logic [31:0] inst_sram_rdata = '0;
  logic        br_taken = 1'b0, br_stall = 1'b0, flush = 1'b0, id_allowin = 1'b0;
  logic [31:0] br_target = '0, flush_target = '0;
  logic        if_to_id_valid, if_to_id_adef;
  logic [31:0] if_to_id_inst, if_to_id_pc;

  if_fetch_queue #(.MAX_OUTST(MAXO), .IBUF_DEPTH(4), .RESET_PC(RPC)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .br_taken(br_taken), .br_target(br_target), .br_stall(br_stall),
    .flush(flush), .flush_target(flush_target),
    .id_allowin(id_allowin), .if_to_id_valid(if_to_id_valid),
    .if_to_id_inst(if_to_id_inst), .if_to_id_pc(if_to_id_pc),
    .if_to_id_adef(if_to_id_adef)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM model: accepted addresses with the cycle their data may return.
  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t rq[$];
  int   cyc = 0;
  int   aok_pct = 100, lat_min = 1, lat_max = 1, allow_pct = 100;

  // Reference: next architectural PC ID should receive.
  logic [31:0] exp_pc = RPC;
  bit          halted = 0, cons_since_flush = 1;
  int          outst_m = 0, n_cons = 0, n_req = 0;
  logic        last_req, last_vld, last_cons_adef;
  logic [31:0] last_addr, last_cons_pc;
  bit          watch_en = 0, watch_hit = 0;
  logic [31:0] watch_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e3779b1) ^ 32'h5a5a1234;
  endfunction

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = RPC + ($urandom_range(1023) << 2);
    if ($urandom_range(99) < 15) t[1:0] = 2'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic model_reset();
    rq.delete();
    outst_m = 0;
    exp_pc = RPC;
    halted = 0;
    cons_since_flush = 1;
  endtask

  task automatic observe();
    int lat;
    last_req = inst_sram_req;
    last_addr = inst_sram_addr;
    last_vld = if_to_id_valid;
    if (!resetn) return;
    if (inst_sram_req) begin
      n_req++;
      chk("req_align", inst_sram_addr[1:0], 2'b00);
      chk("req_stall", br_stall, 1'b0);
      chk("req_outst", outst_m < MAXO, 1'b1);
      if (inst_sram_addr_ok) begin
        lat = $urandom_range(lat_max, lat_min);
        rq.push_back('{addr: inst_sram_addr, due: cyc + lat});
        outst_m++;
        if (watch_en && inst_sram_addr == watch_addr) watch_hit = 1;
      end
    end
    if (inst_sram_data_ok) begin
      void'(rq.pop_front());
      outst_m--;
    end
    if (if_to_id_valid && id_allowin && !(flush || br_taken)) begin
      n_cons++;
      cons_since_flush = 1;
      last_cons_pc = if_to_id_pc;
      last_cons_adef = if_to_id_adef;
      if (halted) begin
        chk("halt_vld", if_to_id_valid, 1'b0);
      end else if (exp_pc[1:0] != 2'b00) begin
        chk("adef_pc", if_to_id_pc, exp_pc);
        chk("adef_flag", if_to_id_adef, 1'b1);
        chk("adef_inst", if_to_id_inst, 32'h0);
        halted = 1;
      end else begin
        chk("pc", if_to_id_pc, exp_pc);
        chk("inst", if_to_id_inst, mem_word(exp_pc));
        chk("adef", if_to_id_adef, 1'b0);
        exp_pc += 4;
      end
    end
    if (flush || br_taken) begin
      exp_pc = flush ? flush_target : br_target;
      halted = 0;
      if (flush) cons_since_flush = 0;
    end
  endtask

  // One cycle: drive at negedge, sample just after, return just past posedge.
  task automatic tick();
    @(negedge clk);
    inst_sram_addr_ok = ($urandom_range(99) < aok_pct);
    id_allowin = ($urandom_range(99) < allow_pct);
    if (resetn && rq.size() > 0 && rq[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst_sram_rdata = mem_word(rq[0].addr);
    end else begin
      inst_sram_data_ok = 1'b0;
      inst_sram_rdata = $urandom;
    end
    #1;
    observe();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_cons(input string tag, input int limit);
    int n0 = n_cons;
    for (int i = 0; i < limit && n_cons == n0; i++) tick();
    chk(tag, n_cons > n0, 1'b1);
  endtask

  task automatic first_req_after_reset(input string tag);
    bit found = 0;
    for (int i = 0; i < 3 && !found; i++) begin
      tick();
      if (last_req) begin
        found = 1;
        chk({tag, "_addr"}, last_addr, RPC);
      end
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    bit got2;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", inst_sram_req, 1'b0);
    chk("rst_vld", if_to_id_valid, 1'b0);
    resetn = 1'b1;

    // Steady stream: one instruction per cycle.
    first_req_after_reset("first_req");
    repeat (10) tick();
    n0 = n_cons;
    repeat (10) tick();
    chk("stream_rate", n_cons - n0, 10);

    // Backpressure fills the buffer and stops requests.
    allow_pct = 0;
    repeat (10) tick();
    chk("bp_req", last_req, 1'b0);
    chk("bp_vld", last_vld, 1'b1);
    chk("bp_outst", outst_m, 0);
    allow_pct = 100;
    n0 = n_cons;
    repeat (10) tick();
    chk("bp_drain", n_cons - n0, 10);

    // Branch with requests in flight.
    lat_min = 2; lat_max = 2;
    got2 = 0;
    for (int i = 0; i < 20 && !got2; i++) begin
      tick();
      got2 = (outst_m == 2);
    end
    chk("br_outst", got2, 1'b1);
    br_taken = 1'b1; br_target = 32'h1c000100;
    tick();
    br_taken = 1'b0;
    wait_cons("br_cons", 30);
    chk("br_next", last_cons_pc, 32'h1c000100);

    // Flush and branch together while the SRAM refuses addresses.
    lat_min = 1; lat_max = 1;
    repeat (5) tick();
    aok_pct = 0;
    watch_en = 1; watch_hit = 0; watch_addr = 32'h1c000300;
    flush = 1'b1; flush_target = 32'h1c000200;
    br_taken = 1'b1; br_target = 32'h1c000300;
    tick();
    flush = 1'b0; br_taken = 1'b0;
    repeat (2) tick();
    aok_pct = 100;
    wait_cons("fl_cons", 30);
    chk("fl_next", last_cons_pc, 32'h1c000200);
    chk("fl_br_never", watch_hit, 1'b0);
    watch_en = 0;

    // Misaligned flush target: single adef entry, then no issue.
    repeat (5) tick();
    flush = 1'b1; flush_target = 32'h1c000102;
    tick();
    flush = 1'b0;
    wait_cons("adef_cons", 30);
    chk("adef_seen", last_cons_adef, 1'b1);
    chk("adef_seen_pc", last_cons_pc, 32'h1c000102);
    n0 = n_req;
    repeat (10) tick();
    chk("halt_noreq", n_req - n0, 0);
    br_taken = 1'b1; br_target = 32'h1c000400;
    tick();
    br_taken = 1'b0;
    wait_cons("resume_cons", 30);
    chk("resume_pc", last_cons_pc, 32'h1c000400);

    // Reset with requests in flight.
    lat_min = 3; lat_max = 3;
    got2 = 0;
    for (int i = 0; i < 20 && !got2; i++) begin
      tick();
      got2 = (outst_m >= 2);
    end
    chk("rst_outst", got2, 1'b1);
    resetn = 1'b0;
    #1;
    chk("rst_async_req", inst_sram_req, 1'b0);
    chk("rst_async_vld", if_to_id_valid, 1'b0);
    model_reset();
    repeat (2) tick();
    resetn = 1'b1;
    first_req_after_reset("rst_first");

    // Randomized traffic against the reference.
    aok_pct = 60; lat_min = 1; lat_max = 4; allow_pct = 70;
    n0 = n_cons;
    for (int i = 0; i < 4000; i++) begin
      br_stall = ($urandom_range(99) < 10);
      if ($urandom_range(999) < 12) begin
        flush = 1'b1; flush_target = rnd_target();
      end else if (cons_since_flush && $urandom_range(99) < 3) begin
        br_taken = 1'b1; br_target = rnd_target();
      end
      tick();
      flush = 1'b0; br_taken = 1'b0;
    end
    br_stall = 1'b0;
    chk("progress", (n_cons - n0) > 200, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
